// File: rtl/multicycle_sequencer.sv
// Stage sequencer for the multi-cycle datapath: IF/ID/EXE/MEM/WB with stage skipping,
// memory wait states, halt and counters. Define MEM_TIMEOUT_EN to add the mem_err timeout.
module multicycle_sequencer #(
    parameter int CNT_W   = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             is_mem,
    input  logic             is_wb,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             en_if,
    output logic             en_id,
    output logic             en_exe,
    output logic             en_mem,
    output logic             en_wb,
    output logic             busy,
    output logic             halted,
    output logic             stall,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
`ifdef MEM_TIMEOUT_EN
    ,
    output logic             mem_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EXE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;
    logic   end_instr;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    // The TIMEOUT-th consecutive not-ready MEM cycle aborts the instruction.
    assign timeout_hit = (state == S_MEM) && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        end_instr  = 1'b0;
        case (state)
            S_IDLE: if (enable) state_next = S_IF;
            S_IF:   state_next = S_ID;
            S_ID:   state_next = S_EXE;
            S_EXE: begin
                if (is_mem)     state_next = S_MEM;
                else if (is_wb) state_next = S_WB;
                else            end_instr  = 1'b1;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_wb) state_next = S_WB;
                    else       end_instr  = 1'b1;
                end
            end
            S_WB:   end_instr = 1'b1;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
        // Instruction boundary: halt takes priority over continuing to run.
        if (end_instr) begin
            if (halt_req)    state_next = S_HALT;
            else if (enable) state_next = S_IF;
            else             state_next = S_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        if (timeout_hit) state_next = S_HALT;
`endif
    end

    assign en_if  = (state == S_IF);
    assign en_id  = (state == S_ID);
    assign en_exe = (state == S_EXE);
    assign en_mem = (state == S_MEM);
    assign en_wb  = (state == S_WB);
    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);
    assign stall  = (state == S_MEM) && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (end_instr) retired <= retired + CNT_W'(1);
            if (busy)      cycles  <= cycles + CNT_W'(1);
        end
    end

`ifdef MEM_TIMEOUT_EN
    // MEM is never re-entered directly from MEM, so clearing outside MEM covers every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state != S_MEM)  wait_cnt <= '0;
            else if (!mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout_hit) mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer; the model expands each
// instruction into its expected list of stages and tracks retired/cycles arithmetically.
module tb_multicycle_sequencer;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    localparam int ST_IDLE = 0;
    localparam int ST_IF   = 1;
    localparam int ST_ID   = 2;
    localparam int ST_EXE  = 3;
    localparam int ST_MEM  = 4;
    localparam int ST_WB   = 5;
    localparam int ST_HALT = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             is_mem;
    logic             is_wb;
    logic             mem_ready;
    logic             halt_req;
    logic             en_if, en_id, en_exe, en_mem, en_wb;
    logic             busy, halted, stall;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] cycles;
`ifdef MEM_TIMEOUT_EN
    logic             mem_err;
    logic             exp_mem_err = 1'b0;
`endif

    int               vectors     = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] exp_retired = '0;
    logic [CNT_W-1:0] exp_cycles  = '0;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .is_mem    (is_mem),
        .is_wb     (is_wb),
        .mem_ready (mem_ready),
        .halt_req  (halt_req),
        .en_if     (en_if),
        .en_id     (en_id),
        .en_exe    (en_exe),
        .en_mem    (en_mem),
        .en_wb     (en_wb),
        .busy      (busy),
        .halted    (halted),
        .stall     (stall),
        .retired   (retired),
        .cycles    (cycles)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_err   (mem_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] stage_onehot(input int st);
        logic [4:0] v;
        v = 5'b00000;
        if (st >= ST_IF && st <= ST_WB) v[5 - st] = 1'b1;
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle(input int st);
        check_output("enables", {59'd0, en_if, en_id, en_exe, en_mem, en_wb}, {59'd0, stage_onehot(st)});
        check_output("busy", {63'd0, busy}, {63'd0, (st >= ST_IF && st <= ST_WB)});
        check_output("halted", {63'd0, halted}, {63'd0, (st == ST_HALT)});
        check_output("stall", {63'd0, stall}, {63'd0, (st == ST_MEM && !mem_ready)});
        check_output("retired", 64'(retired), 64'(exp_retired));
        check_output("cycles", 64'(cycles), 64'(exp_cycles));
`ifdef MEM_TIMEOUT_EN
        check_output("mem_err", {63'd0, mem_err}, {63'd0, exp_mem_err});
`endif
    endtask

    // Sets inputs for one cycle of a given model stage; control inputs outside their
    // valid window are randomized since the sequencer must ignore them.
    task automatic apply_stimulus(input int st, input bit m, input bit wb, input bit rdy,
                                  input bit en, input bit hr);
        is_mem    = (st == ST_IDLE || st == ST_IF) ? 1'($urandom) : m;
        is_wb     = (st == ST_IDLE || st == ST_IF) ? 1'($urandom) : wb;
        mem_ready = (st == ST_MEM) ? rdy : 1'($urandom);
        enable    = en;
        halt_req  = hr;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(ST_IDLE, 1'b0, 1'b0, 1'b0, (i == n - 1), 1'b0);
            #1;
            check_cycle(ST_IDLE);
            @(negedge clk);
        end
    endtask

    // One instruction; abort_at >= 0 asserts reset asynchronously inside that cycle.
    task automatic run_instr(input bit m, input bit wb, input int w, input bit nxt_en,
                             input bit nxt_halt, input int abort_at);
        int seq[$];
        bit rdyq[$];
        seq  = '{ST_IF, ST_ID, ST_EXE};
        rdyq = '{1'b0, 1'b0, 1'b0};
        if (m) begin
            for (int k = 0; k <= w; k++) begin
                seq.push_back(ST_MEM);
                rdyq.push_back(k == w);
            end
        end
        if (wb) begin
            seq.push_back(ST_WB);
            rdyq.push_back(1'b0);
        end
        for (int i = 0; i < seq.size(); i++) begin
            bit last;
            last = (i == seq.size() - 1);
            apply_stimulus(seq[i], m, wb, rdyq[i],
                           last ? nxt_en : 1'($urandom), last ? nxt_halt : 1'($urandom));
            #1;
            check_cycle(seq[i]);
            if (i == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                exp_retired = '0;
                exp_cycles  = '0;
                check_cycle(ST_IDLE);
                return;
            end
            @(negedge clk);
            exp_cycles++;
            if (last) exp_retired++;
        end
    endtask

    initial begin
        reset = 1'b0;
        apply_stimulus(ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check_cycle(ST_IDLE);

        @(negedge clk);
        reset = 1'b1;
        run_idle(1);

        // Directed: WB only, MEM+WB with two wait cycles, then a 3-cycle branch.
        run_instr(1'b0, 1'b1, 0, 1'b1, 1'b0, -1);
        check_output("first_retired", 64'(retired), 64'd1);
        check_output("first_cycles", 64'(cycles), 64'd4);
        run_instr(1'b1, 1'b1, 2, 1'b1, 1'b0, -1);
        check_output("memwb_cycles", 64'(cycles), 64'd11);
        run_instr(1'b0, 1'b0, 0, 1'b1, 1'b0, -1);
        check_output("branch_cycles", 64'(cycles), 64'd14);

        for (int n = 0; n < 150; n++) begin
            bit nxt_en;
            nxt_en = ($urandom_range(0, 3) != 0);
            run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), nxt_en, 1'b0, -1);
            if (!nxt_en) run_idle(int'($urandom_range(1, 3)));
        end

        // Halt requested at the boundary together with enable: halt must win and stick.
        run_instr(1'b1, 1'b0, 1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(ST_HALT, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            #1;
            check_cycle(ST_HALT);
            @(negedge clk);
        end

        // Only reset leaves HALT; then reset again mid-MEM of a fresh instruction.
        reset = 1'b0;
        #1;
        exp_retired = '0;
        exp_cycles  = '0;
        check_cycle(ST_IDLE);
        @(negedge clk);
        reset = 1'b1;
        run_idle(1);
        run_instr(1'b0, 1'b1, 0, 1'b1, 1'b0, -1);
        run_instr(1'b1, 1'b1, 3, 1'b1, 1'b0, 4);
        @(negedge clk);
        #1;
        check_cycle(ST_IDLE);
        reset = 1'b1;
        run_idle(2);
        run_instr(1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
        run_idle(1);

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: abort after TIMEOUT MEM cycles into HALT with mem_err.
        for (int i = 0; i < 3 + TIMEOUT; i++) begin
            int st;
            st = (i < 3) ? i + 1 : ST_MEM;
            apply_stimulus(st, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            #1;
            check_cycle(st);
            @(negedge clk);
            exp_cycles++;
        end
        exp_mem_err = 1'b1;
        apply_stimulus(ST_HALT, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check_cycle(ST_HALT);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
